// File: rtl/audio_decimator_if.sv
// -----------------------------------------------------------------------------
// audio_decimator_if
// Groups the audio sample input stream and the decimated output stream of
// audio_decimator into one bundle.
//   sample_in    [15:0] unsigned expansion audio, midscale 16'h8000
//   sample_tick         one-cycle strobe, sample_in valid
//   out_ready           downstream accepts the head word
//   out_valid           output FIFO non-empty
//   out_data     [15:0] signed two's-complement head word (0 when empty)
//   overflow            sticky: a decimated word was dropped
//   overflow_clr        synchronous clear of overflow
// Modports:
//   master - the decimator (consumes samples, produces output words)
//   slave  - the environment (produces samples, consumes output words)
// -----------------------------------------------------------------------------
interface audio_decimator_if;
  logic [15:0] sample_in;
  logic        sample_tick;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overflow;
  logic        overflow_clr;

  modport master (
    input  sample_in, sample_tick, out_ready, overflow_clr,
    output out_valid, out_data, overflow
  );

  modport slave (
    output sample_in, sample_tick, out_ready, overflow_clr,
    input  out_valid, out_data, overflow
  );
endinterface

// File: rtl/audio_decimator.sv
// -----------------------------------------------------------------------------
// audio_decimator
// Box-car decimator for mixed expansion audio: averages 2^DECIM_LOG2 unsigned
// samples, converts the average to signed two's complement and queues it in a
// small output FIFO for a downstream serializer.
// Parameters:
//   DECIM_LOG2  log2 of samples averaged per output word (1..8)
//   FIFO_DEPTH  output FIFO entries (power of two, 2..16)
// Ports:
//   clk      single system clock, rising edge
//   reset_n  asynchronous active-low reset (deassertion synchronized here)
//   bus      audio_decimator_if.master (sample input, output stream, overflow)
// Optional feature:
//   AUDIO_DECIM_DC_BLOCK_EN  when defined, a first-order DC-blocking high-pass
//   sits between the offset conversion and the FIFO (one extra cycle latency).
// -----------------------------------------------------------------------------
module audio_decimator #(
  parameter int DECIM_LOG2 = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  audio_decimator_if.master  bus
);

  localparam int DL = DECIM_LOG2;
  localparam int AW = 16 + DECIM_LOG2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assert asynchronously, release after two clock edges.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  // Two-flop reset release synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  // ---------------------------------------------------------------------------
  // Accumulate-and-dump decimation
  // ---------------------------------------------------------------------------
  logic [AW-1:0] acc_q, acc_d, sum_s;
  logic [DL-1:0] cnt_q, cnt_d;
  logic [15:0]   avg_q, avg_d;
  logic          strobe_q, strobe_d;
  logic [15:0]   s_s;

  // Next-state for accumulator, counter and average; the wrapping tick is
  // folded into the dumped sum so no sample is lost.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    strobe_d = 1'b0;
    sum_s    = acc_q + {{DL{1'b0}}, bus.sample_in};
    if (bus.sample_tick) begin
      if (cnt_q == {DL{1'b1}}) begin
        avg_d    = sum_s[AW-1:DL];
        acc_d    = {AW{1'b0}};
        cnt_d    = {DL{1'b0}};
        strobe_d = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + DL'(1'b1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Decimation state registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      acc_q    <= {AW{1'b0}};
      cnt_q    <= {DL{1'b0}};
      avg_q    <= 16'h0000;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      avg_q    <= avg_d;
      strobe_q <= strobe_d;
    end
  end

  // Offset binary to two's complement: flipping the MSB recentres midscale.
  assign s_s = avg_q ^ 16'h8000;

  logic        push_s;
  logic [15:0] push_data_s;

`ifdef AUDIO_DECIM_DC_BLOCK_EN
  // ---------------------------------------------------------------------------
  // DC blocker: y = s - s_prev + y_prev - (y_prev >>> 8), saturated to 16 bits.
  // y_prev_q doubles as the word pushed into the FIFO one cycle later.
  // ---------------------------------------------------------------------------
  logic [15:0]        s_prev_q, s_prev_d;
  logic [15:0]        y_prev_q, y_prev_d;
  logic               filt_strobe_q, filt_strobe_d;
  logic signed [17:0] s_ext_s, s_prev_ext_s, y_prev_ext_s, y_full_s;
  logic [15:0]        y_sat_s;

  // Filter arithmetic and saturation
  always_comb begin
    s_ext_s      = $signed({{2{s_s[15]}}, s_s});
    s_prev_ext_s = $signed({{2{s_prev_q[15]}}, s_prev_q});
    y_prev_ext_s = $signed({{2{y_prev_q[15]}}, y_prev_q});
    y_full_s     = s_ext_s - s_prev_ext_s + y_prev_ext_s - (y_prev_ext_s >>> 8);
    if (y_full_s > 18'sd32767) begin
      y_sat_s = 16'h7FFF;
    end else if (y_full_s < -18'sd32768) begin
      y_sat_s = 16'h8000;
    end else begin
      y_sat_s = y_full_s[15:0];
    end
  end

  // Filter state advances only when a new decimated word arrives
  always_comb begin
    s_prev_d      = s_prev_q;
    y_prev_d      = y_prev_q;
    filt_strobe_d = strobe_q;
    if (strobe_q) begin
      s_prev_d = s_s;
      y_prev_d = y_sat_s;
    end else begin
      s_prev_d = s_prev_q;
      y_prev_d = y_prev_q;
    end
  end

  // Filter registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s_prev_q      <= 16'h0000;
      y_prev_q      <= 16'h0000;
      filt_strobe_q <= 1'b0;
    end else begin
      s_prev_q      <= s_prev_d;
      y_prev_q      <= y_prev_d;
      filt_strobe_q <= filt_strobe_d;
    end
  end

  assign push_s      = filt_strobe_q;
  assign push_data_s = y_prev_q;
`else
  assign push_s      = strobe_q;
  assign push_data_s = s_s;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full_s, empty_s, pop_s, do_push_s, drop_s;

  assign full_s    = (count_q == CW'(FIFO_DEPTH));
  assign empty_s   = (count_q == {CW{1'b0}});
  assign pop_s     = !empty_s && bus.out_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;

  // FIFO storage, pointer, occupancy and sticky overflow next-state
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head word is read straight from storage; forced to zero when empty.
  assign bus.out_valid = !empty_s;
  assign bus.out_data  = empty_s ? 16'h0000 : mem_q[rd_ptr_q];
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/audio_decimator.md
AUDIO_DECIMATOR -- requirements
Module: audio_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 5, log2 of samples averaged per output word (legal 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sample_in  input  16  unsigned mixed expansion audio, midscale 0x8000.
REQ-006 SHALL have port sample_tick  input  1  one-cycle strobe, sample_in valid; one per M2 cycle.
REQ-007 SHALL have port out_ready  input  1  downstream serializer accepts head word.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_data  output  16  signed two's-complement head word.
REQ-010 SHALL have port overflow  output  1  sticky: a decimated word was dropped.
REQ-011 SHALL have port overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-012 SHALL keep accumulator acc, width 16+DECIM_LOG2, and sample counter cnt, width DECIM_LOG2.
REQ-013 On sample_tick with cnt != all-ones: acc <= acc + sample_in, cnt <= cnt + 1.
REQ-014 On sample_tick with cnt == all-ones: avg <= (acc + sample_in) >> DECIM_LOG2, acc <= 0, cnt <= 0 (wrap), decim_strobe asserted next cycle; no sample lost.
REQ-015 Cycles without sample_tick SHALL leave acc and cnt unchanged.
REQ-016 Offset conversion: s = avg XOR 0x8000 (0x8000 -> 0, 0xFFFF -> +32767, 0x0000 -> -32768).
REQ-017 Push of s into FIFO SHALL occur on the cycle decim_strobe is high (sample_tick-wrap to out_valid latency 2 cycles when FIFO empty, without DC block).
REQ-018 Pop SHALL occur when out_valid && out_ready; out_data SHALL present the head word combinationally from storage, stable while out_valid && !out_ready.
REQ-019 Push while full and no pop: word dropped, FIFO unchanged, overflow <= 1.
REQ-020 Push and pop same cycle while full: both SHALL complete, no overflow.
REQ-021 Pop while empty SHALL be impossible (out_valid low); out_data SHALL then be 0.
REQ-022 overflow_clr and a simultaneous overflow event: set SHALL win (overflow stays 1).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-024 While reset_n low: acc=0, cnt=0, avg=0, decim_strobe=0, FIFO empty, out_valid=0, out_data=0, overflow=0, DC filter state=0.
REQ-025 Reset asserted mid-decimation SHALL discard the partial sum; first output after release averages the next 2^DECIM_LOG2 ticks.
REQ-026 Deassertion SHALL be synchronized internally (two-flop) before state leaves reset.

Configuration
REQ-027 Macro AUDIO_DECIM_DC_BLOCK_EN defined: s passes a DC-blocking high-pass before the FIFO: y = s - s_prev + y_prev - (y_prev >>> 8), 18-bit internal, saturated to [-32768, +32767], one extra cycle latency (3 total).
REQ-028 Macro AUDIO_DECIM_DC_BLOCK_EN undefined: s pushed directly, no filter registers present, latency per REQ-017.

Verification
REQ-029 Reset, 32 ticks sample_in=0x8000, out_ready=1 -> one word out_data=0x0000, out_valid 2 cycles after 32nd tick (filter off).
REQ-030 32 ticks 0xFFFF then 32 ticks 0x0000 (filter off) -> words 0x7FFF then 0x8000.
REQ-031 out_ready=0, 5 full decimation periods, FIFO_DEPTH=4 -> 4 words held, overflow=1 after 5th; overflow_clr -> 0; drain yields first 4 words in order.
REQ-032 FIFO full, push and pop in same cycle -> occupancy stays 4, overflow stays 0.
REQ-033 reset_n low after 17 ticks of 0xFFFF, release, 32 ticks 0x8000 -> single word 0x0000.
REQ-034 Filter on, constant 0xC000 for 64 periods -> first word 0x4000, subsequent words decaying toward 0, never sign-flipping beyond -1.
